rf_writeback_ctrl: RTL and testbench
====================================

// Module: rf_writeback_ctrl
// PURPOSE
//  Write-back controller driving the RegFile write port (RegWrite/WriteAddr/WriteData).
//  Merges ALU results and LSU load returns into one write per cycle, with a small ALU FIFO.
//  Keeps a per-register busy scoreboard for hazard detection on the read side.
//  Sits between EX/MEM result producers and RegFile, inside the uniprocessor core.
// PARAMETERS
//  DATA_W      64  width of result data (matches RegBus)
//  ADDR_W      5   register address width (matches RegAddrBus)
//  FIFO_DEPTH  4   ALU result FIFO entries, power of two, >=2
// PORTS
//  sys_clk      in   1              core clock; all state updates on posedge
//  rstn         in   1              synchronous active-low reset
//  alu_valid    in   1              ALU result offered this cycle
//  alu_rd       in   ADDR_W         ALU destination register
//  alu_data     in   DATA_W         ALU result
//  alu_ready    out  1              ALU result accepted when alu_valid&alu_ready
//  lsu_valid    in   1              load data offered this cycle
//  lsu_rd       in   ADDR_W         load destination register
//  lsu_data     in   DATA_W         load data
//  lsu_ready    out  1              load accepted when lsu_valid&lsu_ready
//  issue_valid  in   1              instruction with destination issued this cycle
//  issue_rd     in   ADDR_W         its destination register
//  RegWrite     out  1              RegFile write enable (registered)
//  WriteAddr    out  ADDR_W         RegFile write address (registered)
//  WriteData    out  DATA_W         RegFile write data (registered)
//  busy         out  2**ADDR_W      bit n=1: write to xn pending
// BEHAVIOUR
//  Reset (rstn==0 at posedge): RegWrite=0, WriteAddr=0, WriteData=0, FIFO empty, busy=0.
//   alu_ready=0, lsu_ready=0 while rstn==0 (combinational gating).
//  Ready: lsu_ready = rstn & ~fifo_full; alu_ready = rstn & ~fifo_full.
//  Per-cycle select (priority order), result registered onto outputs next posedge:
//   1) fifo_full: pop FIFO head; LSU and ALU stalled.
//   2) lsu accepted: write LSU; accepted ALU result pushes into FIFO.
//   3) FIFO non-empty: pop head; accepted ALU result pushes (push+pop same cycle allowed).
//   4) FIFO empty: accepted ALU result bypasses FIFO, written directly.
//   5) nothing: RegWrite=0 next cycle; WriteAddr/WriteData hold.
//  Latency: bypass/LSU path 1 cycle accept->RegWrite; FIFO path 1 cycle after pop.
//  ALU results retire in acceptance order; no reordering within the FIFO.
//  rd==0 (ALU or LSU): handshake completes, result dropped: not enqueued, no RegWrite.
//  FIFO: circular, pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH; no overflow/underflow.
//  Scoreboard, at posedge:
//   set busy[issue_rd] if issue_valid & issue_rd!=0;
//   clear busy[WriteAddr'] when a write is selected (same edge RegWrite rises).
//   Same rd set and cleared same edge: set wins. busy[0] is constant 0.
//  Issuer guarantees no second producer issued to an rd whose busy bit is 1.
//  Reset mid-operation: FIFO contents and pending results discarded, no write emitted.
// TESTING
//  Bypass: reset, alu_valid rd=5 data=0x11 -> next cycle RegWrite=1,WriteAddr=5,WriteData=0x11.
//  Conflict: same-cycle lsu rd=3 0xAA + alu rd=4 0xBB -> rd3 write cycle+1, rd4 write cycle+2.
//  Full: hold lsu_valid, 5 ALU pushes -> alu_ready/lsu_ready=0 at count 4; FIFO drains in order.
//  x0: alu rd=0 data=0xFF -> alu_ready=1, RegWrite stays 0, busy unchanged.
//  Scoreboard: issue rd=7 -> busy[7]=1; ALU rd=7 write -> busy[7]=0 same edge RegWrite rises.
//  Reset: rstn=0 with 3 FIFO entries -> after release, no RegWrite, busy=0, ready=1.

Source files
------------

// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - register file write-back arbiter with ALU result FIFO and busy scoreboard
// Merges LSU load returns and ALU results into one registered RegFile write per
// cycle. LSU results take priority; ALU results that collide are parked in a
// small in-order FIFO. A per-register busy scoreboard tracks pending writes.
module rf_writeback_ctrl #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   sys_clk,
  input  logic                   rstn,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   lsu_valid,
  input  logic [ADDR_W-1:0]      lsu_rd,
  input  logic [DATA_W-1:0]      lsu_data,
  output logic                   lsu_ready,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_rd,
  output logic                   RegWrite,
  output logic [ADDR_W-1:0]      WriteAddr,
  output logic [DATA_W-1:0]      WriteData,
  output logic [2**ADDR_W-1:0]   busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;

  logic [ADDR_W-1:0] r_mem_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [NREG-1:0]   r_busy;

  logic              w_full;
  logic              w_empty;
  logic              w_alu_acc;
  logic              w_lsu_acc;
  logic              w_alu_keep;
  logic              w_push;
  logic              w_pop;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [NREG-1:0]   w_busy_nxt;

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign alu_ready  = rstn & ~w_full;
  assign lsu_ready  = rstn & ~w_full;
  assign w_alu_acc  = alu_valid & alu_ready;
  assign w_lsu_acc  = lsu_valid & lsu_ready;
  // Results for x0 complete their handshake but are never stored or written.
  assign w_alu_keep = w_alu_acc & (alu_rd != '0);

  assign RegWrite  = r_wr_en;
  assign WriteAddr = r_wr_addr;
  assign WriteData = r_wr_data;
  assign busy      = r_busy;

  // Priority select of this cycle's write source and FIFO push/pop.
  always_comb begin
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_addr = r_wr_addr;
    w_wr_data = r_wr_data;
    if (w_full) begin
      w_pop     = 1'b1;
      w_wr_en   = 1'b1;
      w_wr_addr = r_mem_rd[r_rptr];
      w_wr_data = r_mem_data[r_rptr];
    end else if (w_lsu_acc) begin
      w_push = w_alu_keep;
      if (lsu_rd != '0) begin
        w_wr_en   = 1'b1;
        w_wr_addr = lsu_rd;
        w_wr_data = lsu_data;
      end
    end else if (!w_empty) begin
      w_pop     = 1'b1;
      w_push    = w_alu_keep;
      w_wr_en   = 1'b1;
      w_wr_addr = r_mem_rd[r_rptr];
      w_wr_data = r_mem_data[r_rptr];
    end else if (w_alu_keep) begin
      w_wr_en   = 1'b1;
      w_wr_addr = alu_rd;
      w_wr_data = alu_data;
    end
  end

  // Scoreboard next state: a new issue to the same rd overrides the clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_en) begin
      w_busy_nxt[w_wr_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // FIFO storage; contents are don't-care until counted valid.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= alu_rd;
      r_mem_data[r_wptr] <= alu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered RegFile write port and busy scoreboard.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= '0;
    end else begin
      r_wr_en   <= w_wr_en;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      r_busy    <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb/tb_rf_writeback_ctrl.sv - self-checking bench for rf_writeback_ctrl
module tb_rf_writeback_ctrl;

  localparam int DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [63:0] WriteData;
  logic [31:0] busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
  } ent_t;

  ent_t        m_q[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [63:0] m_wd;
  logic [31:0] m_busy;
  logic [31:0] busy_before;

  rf_writeback_ctrl #(.DATA_W(64), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                       input logic iv, input logic [4:0] ird);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_valid = iv; issue_rd = ird;
  endtask

  // Reference behaviour: one edge of the write-back rules, on a queue.
  task automatic model_edge();
    ent_t e;
    bit full, aacc, lacc;
    if (!rstn) begin
      m_q.delete();
      m_we = 0; m_wa = 0; m_wd = 0; m_busy = 0;
      return;
    end
    full = (m_q.size() == DEPTH);
    aacc = alu_valid && !full;
    lacc = lsu_valid && !full;
    m_we = 0;
    if (full) begin
      e = m_q.pop_front();
      m_we = 1; m_wa = e.rd; m_wd = e.d;
    end else if (lacc) begin
      if (lsu_rd != 0) begin m_we = 1; m_wa = lsu_rd; m_wd = lsu_data; end
      if (aacc && alu_rd != 0) m_q.push_back('{alu_rd, alu_data});
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = 1; m_wa = e.rd; m_wd = e.d;
      if (aacc && alu_rd != 0) m_q.push_back('{alu_rd, alu_data});
    end else if (aacc && alu_rd != 0) begin
      m_we = 1; m_wa = alu_rd; m_wd = alu_data;
    end
    if (m_we) m_busy[m_wa] = 1'b0;
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  // One clock: readies checked mid-low phase, registered outputs checked after the edge.
  task automatic cycle();
    logic exp_rdy;
    #1;
    exp_rdy = rstn && (m_q.size() != DEPTH);
    chk("alu_ready", 64'(alu_ready), 64'(exp_rdy));
    chk("lsu_ready", 64'(lsu_ready), 64'(exp_rdy));
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("RegWrite", 64'(RegWrite), 64'(m_we));
    chk("WriteAddr", 64'(WriteAddr), 64'(m_wa));
    chk("WriteData", WriteData, m_wd);
    chk("busy", 64'(busy), 64'(m_busy));
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  initial begin
    m_we = 0; m_wa = 0; m_wd = 0; m_busy = 0;
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    cycle();
    cycle();
    chk("reset_regwrite", 64'(RegWrite), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    idle(1);

    // bypass
    drive(1, 5, 64'h11, 0, 0, 0, 0, 0);
    cycle();
    chk("bypass_we", 64'(RegWrite), 64'd1);
    chk("bypass_addr", 64'(WriteAddr), 64'd5);
    chk("bypass_data", WriteData, 64'h11);
    idle(1);

    // LSU / ALU conflict
    drive(1, 4, 64'hBB, 1, 3, 64'hAA, 0, 0);
    cycle();
    chk("conflict_lsu_addr", 64'(WriteAddr), 64'd3);
    chk("conflict_lsu_data", WriteData, 64'hAA);
    idle(1);
    chk("conflict_alu_addr", 64'(WriteAddr), 64'd4);
    chk("conflict_alu_data", WriteData, 64'hBB);
    chk("conflict_alu_we", 64'(RegWrite), 64'd1);
    idle(1);

    // fill the FIFO while LSU holds priority
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'(20 + i), 64'(32'h100 + i), 1, 5'(10 + i), 64'(32'h200 + i), 0, 0);
      if (i == 4) begin
        #1;
        chk("full_alu_ready", 64'(alu_ready), 64'd0);
        chk("full_lsu_ready", 64'(lsu_ready), 64'd0);
      end
      cycle();
    end
    chk("full_first_pop", 64'(WriteAddr), 64'd20);
    idle(6);

    // x0 result dropped
    busy_before = m_busy;
    drive(1, 0, 64'hFF, 0, 0, 0, 0, 0);
    #1;
    chk("x0_alu_ready", 64'(alu_ready), 64'd1);
    cycle();
    chk("x0_regwrite", 64'(RegWrite), 64'd0);
    chk("x0_busy", 64'(busy), 64'(busy_before));

    // scoreboard
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    cycle();
    chk("sb_set", 64'(busy[7]), 64'd1);
    drive(1, 7, 64'h77, 0, 0, 0, 0, 0);
    cycle();
    chk("sb_clear", 64'(busy[7]), 64'd0);
    chk("sb_we", 64'(RegWrite), 64'd1);
    // set wins over clear on the same edge
    drive(1, 9, 64'h99, 0, 0, 0, 1, 9);
    cycle();
    chk("sb_set_wins", 64'(busy[9]), 64'd1);
    idle(1);

    // reset with three FIFO entries
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(12 + i), 64'(32'h300 + i), 1, 5'(1 + i), 64'(32'h400 + i), 1, 5'(25 + i));
      cycle();
    end
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    rstn = 1'b1;
    idle(1);
    chk("rst_mid_we", 64'(RegWrite), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    #1;
    chk("rst_mid_ready", 64'(alu_ready), 64'd1);
    idle(1);

    // randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      rstn = ($urandom_range(0, 60) != 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), {$urandom, $urandom},
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), {$urandom, $urandom},
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
      cycle();
    end
    rstn = 1'b1;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
